// File: rtl/thermostat_pkg.sv
// Shared types and constants for the thermostat datapath.
// Contents: day/hour/minute/temperature widths, one-hot day constants,
// the schedule entry record and the entry match helper.
package thermostat_pkg;

  localparam int unsigned C_DAY_W  = 7;
  localparam int unsigned C_HOUR_W = 5;
  localparam int unsigned C_MIN_W  = 6;
  localparam int unsigned C_TEMP_W = 7;

  // bit0 = Sunday .. bit6 = Saturday, matching time_keeper's day output
  localparam logic [C_DAY_W-1:0] C_SUN = 7'h01;
  localparam logic [C_DAY_W-1:0] C_MON = 7'h02;
  localparam logic [C_DAY_W-1:0] C_TUE = 7'h04;
  localparam logic [C_DAY_W-1:0] C_WED = 7'h08;
  localparam logic [C_DAY_W-1:0] C_THU = 7'h10;
  localparam logic [C_DAY_W-1:0] C_FRI = 7'h20;
  localparam logic [C_DAY_W-1:0] C_SAT = 7'h40;

  typedef struct packed {
    logic                valid;
    logic [C_DAY_W-1:0]  day_mask;
    logic [C_HOUR_W-1:0] hour;
    logic [C_MIN_W-1:0]  minute;
    logic [C_TEMP_W-1:0] temp;
  } sched_entry_t;

  function automatic logic entry_matches(input sched_entry_t        e,
                                         input logic [C_DAY_W-1:0]  day,
                                         input logic [C_HOUR_W-1:0] hour,
                                         input logic [C_MIN_W-1:0]  minute);
    return e.valid && (|(e.day_mask & day)) && (e.hour == hour) && (e.minute == minute);
  endfunction

endpackage

// File: rtl/sched_entry_regfile.sv
// Schedule entry storage: g_num_entries records, one synchronous write port
// and one asynchronous read port. Reset clears every entry (so all invalid).
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_wr_en/addr/entry      write strobe, index and record
//   i_rd_addr, o_rd_entry   combinational read of the stored record
module sched_entry_regfile import thermostat_pkg::*; #(
  parameter int unsigned g_num_entries = 8
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_wr_en,
  input  logic [$clog2(g_num_entries)-1:0] i_wr_addr,
  input  sched_entry_t                     i_wr_entry,
  input  logic [$clog2(g_num_entries)-1:0] i_rd_addr,
  output sched_entry_t                     o_rd_entry
);

  sched_entry_t entries_q [g_num_entries];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(g_num_entries); i++) begin
        entries_q[i] <= '0;
      end
    end else if (i_wr_en) begin
      entries_q[i_wr_addr] <= i_wr_entry;
    end
  end

  // Read sees pre-write contents when reading the index being written.
  assign o_rd_entry = entries_q[i_rd_addr];

endmodule

// File: rtl/schedule_engine.sv
// Thermostat schedule engine. Watches the current day/hour/minute and, on
// every change, scans the schedule table one entry per cycle; the lowest
// matching entry's temperature becomes the setpoint. A manual override
// holds until the next applied schedule entry.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_day, i_hour, i_minute        current time (day one-hot)
//   i_wr_*                         schedule entry write port
//   i_override_en/temp             one-cycle manual setpoint strobe
//   o_setpoint, o_setpoint_src     active setpoint, 1 = manual override
//   o_sched_event                  pulse in the cycle an entry is applied
//   o_busy                         scan or apply in progress
module schedule_engine import thermostat_pkg::*; #(
  parameter int unsigned g_num_entries  = 8,
  parameter int unsigned g_temp_width   = C_TEMP_W,
  parameter int unsigned g_default_temp = 70
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [C_DAY_W-1:0]               i_day,
  input  logic [C_HOUR_W-1:0]              i_hour,
  input  logic [C_MIN_W-1:0]               i_minute,
  input  logic                             i_wr_en,
  input  logic [$clog2(g_num_entries)-1:0] i_wr_addr,
  input  logic                             i_wr_valid,
  input  logic [C_DAY_W-1:0]               i_wr_day_mask,
  input  logic [C_HOUR_W-1:0]              i_wr_hour,
  input  logic [C_MIN_W-1:0]               i_wr_minute,
  input  logic [g_temp_width-1:0]          i_wr_temp,
  input  logic                             i_override_en,
  input  logic [g_temp_width-1:0]          i_override_temp,
  output logic [g_temp_width-1:0]          o_setpoint,
  output logic                             o_setpoint_src,
  output logic                             o_sched_event,
  output logic                             o_busy
);

  localparam int unsigned IdxW  = $clog2(g_num_entries);
  localparam int unsigned TimeW = C_DAY_W + C_HOUR_W + C_MIN_W;

  typedef enum logic [1:0] {StIdle, StScan, StApply} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [TimeW-1:0]    snap_q;
  logic [C_TEMP_W-1:0] apply_temp_q;

  logic [TimeW-1:0] time_now;
  logic             time_changed;
  sched_entry_t     wr_entry;
  sched_entry_t     rd_entry;
  logic             hit;
  logic             last_idx;

  assign time_now     = {i_day, i_hour, i_minute};
  assign time_changed = (time_now != snap_q);

  assign wr_entry = '{valid:    i_wr_valid,
                      day_mask: i_wr_day_mask,
                      hour:     i_wr_hour,
                      minute:   i_wr_minute,
                      temp:     C_TEMP_W'(i_wr_temp)};

  sched_entry_regfile #(
    .g_num_entries(g_num_entries)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_entry(wr_entry),
    .i_rd_addr (idx_q),
    .o_rd_entry(rd_entry)
  );

  // Matching is against the snapshot, not the live inputs; a live change
  // restarts the scan anyway.
  assign hit = entry_matches(rd_entry,
                             snap_q[TimeW-1 -: C_DAY_W],
                             snap_q[C_MIN_W +: C_HOUR_W],
                             snap_q[C_MIN_W-1:0]);
  assign last_idx = (idx_q == IdxW'(g_num_entries - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      snap_q         <= '1;  // unreachable time, forces a scan after reset
      apply_temp_q   <= '0;
      o_setpoint     <= g_temp_width'(g_default_temp);
      o_setpoint_src <= 1'b0;
    end else begin
      snap_q <= time_now;
      if (time_changed) begin
        // Any time change abandons the current scan or apply.
        state_q <= StScan;
        idx_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StScan: begin
            if (hit) begin
              state_q      <= StApply;
              apply_temp_q <= rd_entry.temp;
            end else if (last_idx) begin
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StApply: begin
            state_q        <= StIdle;
            o_setpoint     <= g_temp_width'(apply_temp_q);
            o_setpoint_src <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
      // Placed last so an override beats a same-cycle apply.
      if (i_override_en) begin
        o_setpoint     <= i_override_temp;
        o_setpoint_src <= 1'b1;
      end
    end
  end

  // The pulse is withdrawn if the apply is discarded by an override or a
  // time change in the same cycle, so it cannot be registered ahead.
  assign o_sched_event = (state_q == StApply) && !time_changed && !i_override_en;
  assign o_busy        = (state_q != StIdle);

endmodule
